snake_cell_writer: RTL and testbench
====================================

SNAKE_CELL_WRITER -- requirements
Module: snake_cell_writer

Interface
REQ-001 Parameter GRID_W, 64, grid width in cells.
REQ-002 Parameter GRID_H, 48, grid height in cells.
REQ-003 clk  in  1  single system clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_word  in  31  command word from the Nios-written output PIO.
REQ-006 mem_addr  out  12  cell RAM write address.
REQ-007 mem_wdata  out  2  cell RAM write data (0 empty, 1 body, 2 food, 3 head).
REQ-008 mem_we  out  1  cell RAM write request.
REQ-009 mem_ready  in  1  cell RAM accepts the write in any cycle where mem_we and mem_ready are both high.
REQ-010 busy  out  1  high whenever the FSM is not in IDLE.
REQ-011 status_word  out  31  status for the Nios input PIO: [30] busy, [29] err, [28:8] zero, [7:0] drop_count.

Function
REQ-012 cmd_word fields SHALL be: [30] toggle, [29:28] op, [17:16] value, [15:8] y, [7:0] x; all other bits are ignored.
REQ-013 A register last_tog SHALL capture cmd_word[30] every cycle; a new command is detected in a cycle where cmd_word[30] != last_tog.
REQ-014 Ops SHALL be: 00 clear cell (wdata 0), 01 write cell (wdata = value), 10 reserved (no write, no error), 11 clear all.
REQ-015 FSM states SHALL be IDLE, WRITE, CLEAR; reset enters IDLE.
REQ-016 A new command detected in IDLE SHALL be accepted in that cycle; all fields are latched in that cycle.
REQ-017 Op 00/01 with x < GRID_W and y < GRID_H SHALL go to WRITE, with mem_addr = y*GRID_W + x (truncated to 12 bits) and mem_we high from the next cycle.
REQ-018 Op 00/01 with x >= GRID_W or y >= GRID_H SHALL set err, stay in IDLE, and issue no write.
REQ-019 In WRITE, mem_we, mem_addr and mem_wdata SHALL hold stable until the handshake cycle; the FSM returns to IDLE in the next cycle with mem_we low.
REQ-020 Op 11 SHALL clear err on acceptance and enter CLEAR, which writes data 0 to addresses 0 through GRID_W*GRID_H-1 in ascending order, advancing one address per handshake.
REQ-021 CLEAR SHALL return to IDLE in the cycle after the handshake on the last address (3071 at defaults).
REQ-022 A new command detected while busy SHALL be dropped, not queued, and SHALL increment drop_count, which saturates at 255.
REQ-023 A dropped command SHALL be counted once, because last_tog updates in that cycle.
REQ-024 mem_ready held low SHALL stall WRITE/CLEAR indefinitely without changing any output.
REQ-025 In IDLE, mem_we SHALL be low; mem_addr and mem_wdata are don't-care.
REQ-026 busy SHALL equal (state != IDLE) as a registered output.
REQ-027 status_word SHALL be a combinational image of the busy, err and drop_count registers.

Reset
REQ-028 Reset SHALL set state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, err 0, drop_count 0, and last_tog to the current cmd_word[30], so no command is seen on the first post-reset cycle.
REQ-029 Reset asserted mid-WRITE or mid-CLEAR SHALL abort the operation in the same clock edge, with no further writes issued.

Verification
REQ-030 cmd toggle with op 01, x=5, y=2, value=2, mem_ready=1 -> one cycle of mem_we with mem_addr=133 and mem_wdata=2, busy high for 1 cycle.
REQ-031 op 01 with x=64, y=0 -> no mem_we, status_word[29]=1; a later op 11 -> err back to 0.
REQ-032 op 11 with mem_ready=1 -> 3072 consecutive writes at addresses 0..3071 with data 0, then busy=0.
REQ-033 op 11 followed by 300 toggles during CLEAR -> drop_count=255 (saturated), and the clear completes unaffected.
REQ-034 op 00 at x=1, y=1 with mem_ready low for 10 cycles -> mem_we and mem_addr=65 held for 10 cycles, write completes on the 11th.
REQ-035 reset asserted at CLEAR address 100 -> mem_we=0 in the next cycle, then IDLE, all status zero, and no spurious command after reset release.

Source files
------------

// File: rtl/snake_cell_writer.sv
// Cell RAM writer for the snake grid: decodes toggle-framed commands from a PIO
// word and issues single-cell writes or a full-grid clear over a ready handshake.
module snake_cell_writer #(
  parameter int unsigned GRID_W = 64,
  parameter int unsigned GRID_H = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [30:0] cmd_word,
  output logic [11:0] mem_addr,
  output logic [1:0]  mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        busy,
  output logic [30:0] status_word
);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  localparam logic [11:0] LAST_ADDR = 12'(GRID_W * GRID_H - 1);

  state_t      r_state;
  logic        r_last_tog;
  logic        r_err;
  logic        r_busy;
  logic        r_mem_we;
  logic [11:0] r_mem_addr;
  logic [1:0]  r_mem_wdata;
  logic [7:0]  r_drop;

  logic        w_new;
  logic [1:0]  w_op;
  logic [1:0]  w_val;
  logic [7:0]  w_x;
  logic [7:0]  w_y;
  logic        w_in_range;
  logic [11:0] w_lin;
  logic        w_hs;
  logic [9:0]  w_unused_bits;

  assign w_new         = cmd_word[30] != r_last_tog;
  assign w_op          = cmd_word[29:28];
  assign w_val         = cmd_word[17:16];
  assign w_y           = cmd_word[15:8];
  assign w_x           = cmd_word[7:0];
  assign w_unused_bits = cmd_word[27:18];
  assign w_in_range    = (32'(w_x) < GRID_W) && (32'(w_y) < GRID_H);
  assign w_lin         = 12'(w_y) * 12'(GRID_W) + 12'(w_x);
  assign w_hs          = r_mem_we && mem_ready;

  always_ff @(posedge clk) begin
    // last_tog always follows the toggle bit, so each command is seen exactly once
    r_last_tog <= cmd_word[30];
    if (reset) begin
      r_state     <= IDLE;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_drop      <= '0;
    end else begin
      if (w_new && r_state != IDLE && r_drop != 8'hFF)
        r_drop <= r_drop + 8'd1;
      unique case (r_state)
        IDLE: begin
          if (w_new) begin
            unique case (w_op)
              2'b00, 2'b01: begin
                if (w_in_range) begin
                  r_state     <= WRITE;
                  r_busy      <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= w_lin;
                  r_mem_wdata <= (w_op == 2'b01) ? w_val : 2'd0;
                end else begin
                  r_err <= 1'b1;
                end
              end
              2'b11: begin
                r_err       <= 1'b0;
                r_state     <= CLEAR;
                r_busy      <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= '0;
                r_mem_wdata <= '0;
              end
              default: ;
            endcase
          end
        end
        WRITE: begin
          if (w_hs) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_mem_we <= 1'b0;
          end
        end
        CLEAR: begin
          if (w_hs) begin
            if (r_mem_addr == LAST_ADDR) begin
              r_state  <= IDLE;
              r_busy   <= 1'b0;
              r_mem_we <= 1'b0;
            end else begin
              r_mem_addr <= r_mem_addr + 12'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign busy        = r_busy;
  assign status_word = {r_busy, r_err, 21'd0, r_drop};

endmodule

// File: tb/tb_snake_cell_writer.sv
// Scoreboard bench for snake_cell_writer: expected RAM writes are queued when
// commands are issued and retired by a monitor at each accepted handshake.
module tb_snake_cell_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [30:0] cmd_word;
  logic [11:0] mem_addr;
  logic [1:0]  mem_wdata;
  logic        mem_we;
  logic        mem_ready;
  logic        busy;
  logic [30:0] status_word;

  int tests = 0;
  int fails = 0;
  logic [13:0] exp_q[$];

  always #5 clk = ~clk;

  snake_cell_writer #(.GRID_W(64), .GRID_H(48)) dut (
    .clk(clk), .reset(reset), .cmd_word(cmd_word), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
    .busy(busy), .status_word(status_word)
  );

  always @(negedge clk) begin
    if (mem_we === 1'b1 && mem_ready === 1'b1) begin
      logic [13:0] e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          fails++;
          $display("FAIL write_data: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                   mem_addr, mem_wdata, e[13:2], e[1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] y, input logic [7:0] x,
                      input logic [1:0] value);
    cmd_word = {~cmd_word[30], op, 10'd0, value, y, x};
  endtask

  task automatic push_clear(input int unsigned n);
    for (int unsigned a = 0; a < n; a++) exp_q.push_back({12'(a), 2'd0});
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 4000 && busy; i++) tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_timeout: busy=%b, expected 0", name, busy);
    end
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drained: %0d writes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; cmd_word = '0;
    tick(); tick();
    cmd_word[30] = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick();
    tests++;
    if ({mem_we, busy, mem_addr, mem_wdata} !== 16'd0) begin
      fails++;
      $display("FAIL reset_outputs: we=%b busy=%b addr=%0d data=%0d, expected all 0",
               mem_we, busy, mem_addr, mem_wdata);
    end
    tests++;
    if (status_word !== 31'd0) begin
      fails++;
      $display("FAIL reset_status: got %h, expected 0", status_word);
    end
  endtask

  task automatic test_write();
    mem_ready = 1'b1;
    exp_q.push_back({12'd133, 2'd2});
    send(2'b01, 8'd2, 8'd5, 2'd2);
    tick();
    tests++;
    if ({busy, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'd133, 2'd2}) begin
      fails++;
      $display("FAIL write_issue: busy=%b we=%b addr=%0d data=%0d, expected 1 1 133 2",
               busy, mem_we, mem_addr, mem_wdata);
    end
    tick();
    tests++;
    if ({busy, mem_we} !== 2'b00) begin
      fails++;
      $display("FAIL write_done: busy=%b we=%b, expected 0 0", busy, mem_we);
    end
    // far corner cell and a clear-cell op (value field must be ignored)
    exp_q.push_back({12'd3071, 2'd3});
    send(2'b01, 8'd47, 8'd63, 2'd3);
    tick(); tick();
    exp_q.push_back({12'd0, 2'd0});
    send(2'b00, 8'd0, 8'd0, 2'd3);
    tick(); tick(); tick();
    check_drained("write");
  endtask

  task automatic test_err_and_clear();
    mem_ready = 1'b1;
    send(2'b01, 8'd0, 8'd64, 2'd1);
    tick(); tick();
    tests++;
    if ({mem_we, busy, status_word[29]} !== 3'b001) begin
      fails++;
      $display("FAIL err_x: we=%b busy=%b err=%b, expected 0 0 1", mem_we, busy, status_word[29]);
    end
    send(2'b00, 8'd48, 8'd0, 2'd0);
    tick(); tick();
    send(2'b10, 8'd1, 8'd1, 2'd1);
    tick(); tick();
    tests++;
    if ({mem_we, busy, status_word[29]} !== 3'b001) begin
      fails++;
      $display("FAIL err_y_reserved: we=%b busy=%b err=%b, expected 0 0 1",
               mem_we, busy, status_word[29]);
    end
    push_clear(3072);
    send(2'b11, 8'd0, 8'd0, 2'd0);
    tick();
    tests++;
    if ({busy, status_word[29]} !== 2'b10) begin
      fails++;
      $display("FAIL clear_err: busy=%b err=%b, expected 1 0", busy, status_word[29]);
    end
    wait_idle("clear");
    check_drained("clear");
    tests++;
    if (status_word !== 31'd0) begin
      fails++;
      $display("FAIL clear_status: got %h, expected 0", status_word);
    end
  endtask

  task automatic test_stall();
    mem_ready = 1'b0;
    exp_q.push_back({12'd65, 2'd0});
    send(2'b00, 8'd1, 8'd1, 2'd2);
    tick();
    for (int i = 0; i < 10; i++) begin
      tests++;
      if ({mem_we, busy, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'd65, 2'd0}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: we=%b busy=%b addr=%0d data=%0d, expected 1 1 65 0",
                 i, mem_we, busy, mem_addr, mem_wdata);
      end
      tick();
    end
    mem_ready = 1'b1;
    tick();
    tests++;
    if ({mem_we, busy} !== 2'b00) begin
      fails++;
      $display("FAIL stall_done: we=%b busy=%b, expected 0 0", mem_we, busy);
    end
    check_drained("stall");
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    push_clear(3072);
    send(2'b11, 8'd0, 8'd0, 2'd0);
    tick();
    for (int i = 0; i < 300; i++) begin
      send(2'b01, 8'd3, 8'd3, 2'd1);
      tick();
      if (i == 9) begin
        tests++;
        if (status_word[7:0] !== 8'd10) begin
          fails++;
          $display("FAIL drop_count_10: got %0d, expected 10", status_word[7:0]);
        end
      end
    end
    wait_idle("drop_clear");
    check_drained("drop_clear");
    tests++;
    if (status_word[7:0] !== 8'd255) begin
      fails++;
      $display("FAIL drop_saturate: got %0d, expected 255", status_word[7:0]);
    end
  endtask

  task automatic test_reset_mid_clear();
    mem_ready = 1'b1;
    push_clear(101);
    send(2'b11, 8'd0, 8'd0, 2'd0);
    tick();
    for (int i = 0; i < 200 && mem_addr != 12'd100; i++) tick();
    tests++;
    if (mem_addr !== 12'd100 || mem_we !== 1'b1) begin
      fails++;
      $display("FAIL reach_addr100: addr=%0d we=%b, expected 100 1", mem_addr, mem_we);
    end
    reset = 1'b1;
    tick();
    tests++;
    if ({mem_we, busy, status_word} !== 33'd0) begin
      fails++;
      $display("FAIL abort_clear: we=%b busy=%b status=%h, expected 0 0 0", mem_we, busy, status_word);
    end
    send(2'b01, 8'd2, 8'd2, 2'd1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if ({mem_we, busy, status_word} !== 33'd0) begin
      fails++;
      $display("FAIL post_reset_idle: we=%b busy=%b status=%h, expected 0 0 0",
               mem_we, busy, status_word);
    end
    check_drained("reset_mid_clear");
  endtask

  initial begin
    test_reset();
    test_write();
    test_err_and_clear();
    test_stall();
    test_back_to_back();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
